// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants and types for the 4-digit 7-segment scanner.
// Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [6:0] seg_t;
    typedef logic [1:0] idx_t;

    // Active-low {g,f,e,d,c,b,a} patterns
    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;

    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    function automatic logic [NUM_DIGITS-1:0] an_select(input idx_t idx);
        logic [NUM_DIGITS-1:0] onehot;
        onehot = 4'b0001 << idx;
        return ~onehot;
    endfunction

endpackage : seg_pkg
`default_nettype wire

// File: rtl/bcd7seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd7seg
// Description : BCD nibble to active-low 7-segment pattern; 10..15 blank.
// Revision    : 1.0  initial release
// ============================================================================
module bcd7seg
    import seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule : bcd7seg
`default_nettype wire

// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan
// Description : Multiplexed 4-digit 7-segment driver with frame snapshot and
//               per-pair blink for clock adjust mode.
// Revision    : 1.0  initial release
// ============================================================================
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
)(
    input  logic        clk,
    input  logic        RESET,
    input  logic [15:0] digits,
    input  logic        blink_en,
    input  logic        blink_sel,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [SCAN_W-1:0]  C_SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] C_BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam idx_t               C_IDX_LAST   = idx_t'(NUM_DIGITS - 1);

    logic [SCAN_W-1:0]  r_scan_cnt;
    logic [BLINK_W-1:0] r_blink_cnt;
    idx_t               r_idx;
    logic               r_phase;
    logic [15:0]        r_snap_digits;
    logic [3:0]         r_snap_dp;

    logic               w_scan_tc;
    logic               w_blink_tc;
    logic [3:0]         w_nibble;
    seg_t               w_seg;
    logic               w_in_pair;
    logic               w_hide;

    assign w_scan_tc  = (r_scan_cnt == C_SCAN_LAST);
    assign w_blink_tc = (r_blink_cnt == C_BLINK_LAST);
    assign w_nibble   = r_snap_digits[{r_idx, 2'b00} +: 4];

    // blink_sel=0 selects digits 3:2 (idx bit1 set), 1 selects digits 1:0
    assign w_in_pair  = (r_idx[1] != blink_sel);
    assign w_hide     = blink_en & r_phase & w_in_pair;

    bcd7seg u_bcd7seg (
        .i_bcd (w_nibble),
        .o_seg (w_seg)
    );

    // Scan counter, digit index and frame snapshot
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_scan_cnt    <= '0;
            r_idx         <= '0;
            r_snap_digits <= '0;
            r_snap_dp     <= '0;
        end else if (w_scan_tc) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + idx_t'(1);
            if (r_idx == C_IDX_LAST) begin
                r_snap_digits <= digits;
                r_snap_dp     <= dp_mask;
            end
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    // Free-running blink timebase, independent of the scan timing
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_blink_tc) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
    end

    // Registered pins; blink controls are sampled live, not from the snapshot
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= w_hide ? AN_OFF : an_select(r_idx);
            seg <= w_seg;
            dp  <= ~r_snap_dp[r_idx];
        end
    end

endmodule : seg_scan
`default_nettype wire

// File: tb/tb_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan
// Description : Randomized self-checking bench for seg_scan against a
//               cycle-count reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seg_scan;

    localparam int S = 4;
    localparam int B = 32;
    localparam int HMAX = 4096;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] digits = 16'h0000;
    logic        blink_en = 1'b0;
    logic        blink_sel = 1'b0;
    logic [3:0]  dp_mask = 4'b0000;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;

    // Inputs as seen at clock edge t (t=1 is the first edge after release)
    logic [15:0] h_dig [0:HMAX-1];
    logic [3:0]  h_dpm [0:HMAX-1];
    logic        h_be  [0:HMAX-1];
    logic        h_bs  [0:HMAX-1];

    seg_scan #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (
        .clk       (clk),
        .RESET     (RESET),
        .digits    (digits),
        .blink_en  (blink_en),
        .blink_sel (blink_sel),
        .dp_mask   (dp_mask),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0d got=%h expected=%h", tag, t, got, exp);
    endtask

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] tbl [0:9];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        if (v > 4'd9) return 7'b1111111;
        return tbl[v];
    endfunction

    // Outputs after edge t show the digit selected after edge t-1, taken
    // from the frame latched at the last multiple of 4*S edges.
    function automatic logic [11:0] model(input int tt);
        int          i, f, ph;
        logic [15:0] d;
        logic [3:0]  m, a, sel_bit;
        logic        hide;
        i  = ((tt - 1) / S) % 4;
        f  = ((tt - 1) / (4 * S)) * (4 * S);
        ph = ((tt - 1) / B) % 2;
        d  = (f > 0) ? h_dig[f] : 16'h0000;
        m  = (f > 0) ? h_dpm[f] : 4'h0;
        hide = h_be[tt] && (ph == 1) && (h_bs[tt] ? (i < 2) : (i >= 2));
        sel_bit = 4'b0001 << i;
        a = hide ? 4'b1111 : ~sel_bit;
        return {a, decode(d[i*4 +: 4]), ~m[i]};
    endfunction

    task automatic run_cycles(input int n, input bit rnd);
        logic [11:0] e;
        for (int k = 0; k < n; k++) begin
            if (rnd) begin
                if ($urandom_range(0, 9) == 0) digits = 16'($urandom);
                if ($urandom_range(0, 9) == 0) dp_mask = 4'($urandom);
                if ($urandom_range(0, 39) == 0) blink_en = ~blink_en;
                if ($urandom_range(0, 39) == 0) blink_sel = ~blink_sel;
            end
            h_dig[t+1] = digits;
            h_dpm[t+1] = dp_mask;
            h_be[t+1]  = blink_en;
            h_bs[t+1]  = blink_sel;
            @(posedge clk);
            t++;
            @(negedge clk);
            e = model(t);
            check("an",  32'(an),  32'(e[11:8]));
            check("seg", 32'(seg), 32'(e[7:1]));
            check("dp",  32'(dp),  32'(e[0]));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_an"},  32'(an),  32'hF);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_dp"},  32'(dp),  32'h1);
    endtask

    initial begin
        digits = 16'h1234;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");

        // Fixed frame content first: first frame all zeros, then 1234
        RESET = 1'b0;
        t = 0;
        run_cycles(40, 1'b0);

        // Mid-frame change must wait for the next frame boundary
        run_cycles(6, 1'b0);
        digits = 16'h5678;
        run_cycles(30, 1'b0);

        // Non-BCD digits and decimal points
        digits  = 16'hABCD;
        dp_mask = 4'b0101;
        run_cycles(40, 1'b0);

        // Blink each pair through full phases
        digits   = 16'h0942;
        blink_en = 1'b1;
        blink_sel = 1'b0;
        run_cycles(80, 1'b0);
        blink_sel = 1'b1;
        run_cycles(80, 1'b0);
        blink_en = 1'b0;
        run_cycles(10, 1'b0);

        // Asynchronous reset while digit index 2 is active
        for (int k = 0; k < 20 && ((t / S) % 4) != 2; k++) run_cycles(1, 1'b0);
        check("idx2_reached", 32'((t / S) % 4), 32'd2);
        #2 RESET = 1'b1;
        #1 check_reset_vals("arst");
        @(negedge clk);
        check_reset_vals("arst_hold");
        RESET = 1'b0;
        t = 0;

        run_cycles(700, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_seg_scan
`default_nettype wire

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clk cycles each digit is lit; legal range >= 2.
REQ-002 Parameter BLINK_DIV, default 25000000, clk cycles per blink half-period; legal range >= 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 digits  input  16  four BCD nibbles; [3:0] = digit 0 (rightmost) ... [15:12] = digit 3 (leftmost).
REQ-006 blink_en  input  1  adjust mode; 1 = selected digit pair blinks.
REQ-007 blink_sel  input  1  0 = digits 3:2 (minutes) blink, 1 = digits 1:0 (seconds) blink.
REQ-008 dp_mask  input  4  bit i = 1 lights the decimal point of digit i.
REQ-009 an  output  4  anode enables, active-low, one-hot-low while scanning.
REQ-010 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal point cathode, active-low.

Function
REQ-012 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; at terminal count, digit index SHALL advance 0->1->2->3->0.
REQ-013 Frame snapshot register SHALL load digits and dp_mask on the edge where the index wraps 3->0; digits/dp_mask changes at any other time SHALL NOT alter the current frame.
REQ-014 an, seg, dp SHALL be registered, reflecting the index and snapshot one cycle after the index changes (latency 1).
REQ-015 For index i: an = all 1s except bit i = 0; seg = decode(snapshot nibble i); dp = ~snapshot dp bit i.
REQ-016 Decode (active-low {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; 10..15 = 1111111 (blank).
REQ-017 Blink counter SHALL count 0..BLINK_DIV-1 free-running; blink phase SHALL toggle at each terminal count.
REQ-018 When blink_en=1, blink phase=1 and index is in the selected pair, an SHALL be 1111 for that slot; seg and dp retain decoded values.
REQ-019 blink_en and blink_sel are not snapshotted; a change SHALL take effect on the next output register update.
REQ-020 Scan step and blink toggle in the same cycle SHALL be independent; neither delays the other.
REQ-021 blink_en deasserting with phase=1 SHALL restore the anode on the next cycle without waiting for a phase toggle.

Reset
REQ-022 While RESET=1: an=1111, seg=1111111, dp=1, scan counter=0, index=0, blink counter=0, phase=0, snapshot digits=0, snapshot dp_mask=0.
REQ-023 First rising clk edge after RESET deasserts SHALL give an=1110, seg=1000000, dp=1.
REQ-024 RESET asserted mid-frame SHALL force reset values immediately, independent of clk.

Structure
REQ-025 Shared package seg_pkg SHALL hold NUM_DIGITS=4, SEG_BLANK=7'b1111111, AN_OFF=4'b1111 and the BCD code constants.
REQ-026 BCD-to-segment decode SHALL be one combinational sub-module bcd7seg (4-bit in, 7-bit active-low out), instantiated once.

Verification (SCAN_DIV=4, BLINK_DIV=32)
REQ-027 Reset release, digits=16'h1234 held -> first frame shows 0 on all digits (an 1110,1101,1011,0111 every 4 cycles); second frame digit0 seg=0011001 (4), digit3 seg=1111001 (1).
REQ-028 digits changes 16'h1234->16'h5678 mid-frame -> current frame unchanged; next frame digit0 seg=0000000 (8).
REQ-029 digits=16'hABCD, dp_mask=4'b0101 -> seg=1111111 on all digits; dp=0 only while an=1110 or 1011.
REQ-030 blink_en=1, blink_sel=0 -> an never 1011/0111 during phase=1 (32 cycles), normal during phase=0; blink_sel=1 -> same for 1110/1101.
REQ-031 RESET pulse asserted mid-scan at index 2 -> an=1111, seg=1111111 asynchronously; scan resumes at index 0 with an=1110 after release.
